// File: rtl/wt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wt_mem_arbiter
// Brief    : N-client arbiter between write-through L1 caches and one memory
//            adapter; tags requests with the client index, routes returns.
// Revision : 1.0 - initial release
// ============================================================================
module wt_mem_arbiter #(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned TID_WIDTH       = 2,
    parameter int unsigned PAYLOAD_WIDTH   = 128,
    parameter int unsigned RTRN_WIDTH      = 192,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned STRICT_PRIO     = 0,
    localparam int unsigned c_port_w       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned c_gtid_w       = c_port_w + TID_WIDTH,
    localparam int unsigned c_cnt_w        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_PORTS-1:0]               req_valid_i,
    output logic [NUM_PORTS-1:0]               req_ready_o,
    input  logic [NUM_PORTS*TID_WIDTH-1:0]     req_txid_i,
    input  logic [NUM_PORTS*PAYLOAD_WIDTH-1:0] req_payload_i,
    output logic                               mem_req_valid_o,
    input  logic                               mem_req_ready_i,
    output logic [c_gtid_w-1:0]                mem_req_txid_o,
    output logic [PAYLOAD_WIDTH-1:0]           mem_req_payload_o,
    input  logic                               mem_rtrn_valid_i,
    input  logic [c_gtid_w-1:0]                mem_rtrn_txid_i,
    input  logic [RTRN_WIDTH-1:0]              mem_rtrn_payload_i,
    output logic [NUM_PORTS-1:0]               rtrn_valid_o,
    output logic [TID_WIDTH-1:0]               rtrn_txid_o,
    output logic [RTRN_WIDTH-1:0]              rtrn_payload_o,
    output logic                               idle_o,
    output logic                               err_o
);

    logic                     r_mem_req_valid;
    logic [c_gtid_w-1:0]      r_mem_req_txid;
    logic [PAYLOAD_WIDTH-1:0] r_mem_req_payload;
    logic [c_port_w-1:0]      r_rr_ptr;
    logic                     r_err;

    logic [NUM_PORTS-1:0]     w_eligible;
    logic [NUM_PORTS-1:0]     w_cnt_nz;
    logic [NUM_PORTS-1:0]     w_grant_vec;
    logic [NUM_PORTS-1:0]     w_rtrn_hit;
    logic [TID_WIDTH-1:0]     w_txid    [NUM_PORTS];
    logic [PAYLOAD_WIDTH-1:0] w_payload [NUM_PORTS];

    logic                     w_can_load;
    logic                     w_found;
    logic                     w_grant;
    logic [c_port_w-1:0]      w_winner;
    logic [c_port_w-1:0]      w_idx;
    logic [c_port_w:0]        w_sum;
    logic [c_port_w-1:0]      w_rr_next;
    logic [c_port_w-1:0]      w_rtrn_port;
    logic                     w_spurious;

    assign w_can_load  = !r_mem_req_valid || mem_req_ready_i;
    assign w_rtrn_port = mem_rtrn_txid_i[c_gtid_w-1:TID_WIDTH];

    // Per-client slice of the packed inputs plus the outstanding counter
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [c_cnt_w-1:0] r_cnt;

        assign w_txid[i]      = req_txid_i[i*TID_WIDTH +: TID_WIDTH];
        assign w_payload[i]   = req_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        assign w_cnt_nz[i]    = (r_cnt != '0);
        assign w_eligible[i]  = req_valid_i[i] && (r_cnt < c_cnt_w'(MAX_OUTSTANDING));
        assign w_grant_vec[i] = w_grant && (w_winner == c_port_w'(i));
        assign w_rtrn_hit[i]  = mem_rtrn_valid_i && (w_rtrn_port == c_port_w'(i)) && w_cnt_nz[i];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt <= '0;
            end else if (w_grant_vec[i] && !w_rtrn_hit[i]) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end else if (!w_grant_vec[i] && w_rtrn_hit[i]) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end
    end

    // Search order starts at the rotating pointer, or at port 0 for fixed priority
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (STRICT_PRIO != 0) begin
                w_sum = (c_port_w+1)'(k);
            end else begin
                w_sum = {1'b0, r_rr_ptr} + (c_port_w+1)'(k);
                if (w_sum >= (c_port_w+1)'(NUM_PORTS)) begin
                    w_sum = w_sum - (c_port_w+1)'(NUM_PORTS);
                end
            end
            w_idx = w_sum[c_port_w-1:0];
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant   = w_found && w_can_load && rst_ni;
    assign w_rr_next = (w_winner == c_port_w'(NUM_PORTS - 1)) ? '0 : (w_winner + c_port_w'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem_req_valid   <= 1'b0;
            r_mem_req_txid    <= '0;
            r_mem_req_payload <= '0;
            r_rr_ptr          <= '0;
        end else if (w_grant) begin
            r_mem_req_valid   <= 1'b1;
            r_mem_req_txid    <= {w_winner, w_txid[w_winner]};
            r_mem_req_payload <= w_payload[w_winner];
            r_rr_ptr          <= w_rr_next;
        end else if (mem_req_ready_i) begin
            r_mem_req_valid   <= 1'b0;
        end
    end

    // A return is spurious when no client owns an outstanding slot for it
    assign w_spurious = mem_rtrn_valid_i && !(|w_rtrn_hit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_spurious) begin
            r_err <= 1'b1;
        end
    end

    assign req_ready_o       = w_grant_vec;
    assign mem_req_valid_o   = r_mem_req_valid;
    assign mem_req_txid_o    = r_mem_req_txid;
    assign mem_req_payload_o = r_mem_req_payload;
    assign rtrn_valid_o      = rst_ni ? w_rtrn_hit : '0;
    assign rtrn_txid_o       = mem_rtrn_txid_i[TID_WIDTH-1:0];
    assign rtrn_payload_o    = mem_rtrn_payload_i;
    assign idle_o            = !(|w_cnt_nz) && !r_mem_req_valid;
    assign err_o             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_mem_arbiter
// Brief    : Scoreboard bench for wt_mem_arbiter (3 ports, round-robin) plus a
//            fixed-priority instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wt_mem_arbiter;

    localparam int c_n   = 3;
    localparam int c_tid = 2;
    localparam int c_pw  = 16;
    localparam int c_rw  = 16;
    localparam int c_max = 2;
    localparam int c_gw  = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [c_n-1:0]        req_valid_i;
    logic [c_n-1:0]        req_ready_o;
    logic [c_n*c_tid-1:0]  req_txid_i;
    logic [c_n*c_pw-1:0]   req_payload_i;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [c_gw-1:0]       mem_req_txid_o;
    logic [c_pw-1:0]       mem_req_payload_o;
    logic                  mem_rtrn_valid_i;
    logic [c_gw-1:0]       mem_rtrn_txid_i;
    logic [c_rw-1:0]       mem_rtrn_payload_i;
    logic [c_n-1:0]        rtrn_valid_o;
    logic [c_tid-1:0]      rtrn_txid_o;
    logic [c_rw-1:0]       rtrn_payload_o;
    logic                  idle_o;
    logic                  err_o;

    logic [c_n-1:0]        sp_req_valid_i;
    logic [c_n-1:0]        sp_req_ready_o;
    logic                  sp_mem_req_valid_o;
    logic [c_gw-1:0]       sp_mem_req_txid_o;
    logic [c_pw-1:0]       sp_mem_req_payload_o;
    logic [c_n-1:0]        sp_rtrn_valid_o;
    logic [c_tid-1:0]      sp_rtrn_txid_o;
    logic [c_rw-1:0]       sp_rtrn_payload_o;
    logic                  sp_idle_o;
    logic                  sp_err_o;

    always #5 clk_i = ~clk_i;

    wt_mem_arbiter #(
        .NUM_PORTS(c_n), .TID_WIDTH(c_tid), .PAYLOAD_WIDTH(c_pw),
        .RTRN_WIDTH(c_rw), .MAX_OUTSTANDING(c_max), .STRICT_PRIO(0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_txid_i(req_txid_i), .req_payload_i(req_payload_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_txid_o(mem_req_txid_o), .mem_req_payload_o(mem_req_payload_o),
        .mem_rtrn_valid_i(mem_rtrn_valid_i), .mem_rtrn_txid_i(mem_rtrn_txid_i),
        .mem_rtrn_payload_i(mem_rtrn_payload_i),
        .rtrn_valid_o(rtrn_valid_o), .rtrn_txid_o(rtrn_txid_o),
        .rtrn_payload_o(rtrn_payload_o), .idle_o(idle_o), .err_o(err_o)
    );

    wt_mem_arbiter #(
        .NUM_PORTS(c_n), .TID_WIDTH(c_tid), .PAYLOAD_WIDTH(c_pw),
        .RTRN_WIDTH(c_rw), .MAX_OUTSTANDING(8), .STRICT_PRIO(1)
    ) dut_sp (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(sp_req_valid_i), .req_ready_o(sp_req_ready_o),
        .req_txid_i(req_txid_i), .req_payload_i(req_payload_i),
        .mem_req_valid_o(sp_mem_req_valid_o), .mem_req_ready_i(1'b1),
        .mem_req_txid_o(sp_mem_req_txid_o), .mem_req_payload_o(sp_mem_req_payload_o),
        .mem_rtrn_valid_i(1'b0), .mem_rtrn_txid_i(4'h0),
        .mem_rtrn_payload_i(16'h0),
        .rtrn_valid_o(sp_rtrn_valid_o), .rtrn_txid_o(sp_rtrn_txid_o),
        .rtrn_payload_o(sp_rtrn_payload_o), .idle_o(sp_idle_o), .err_o(sp_err_o)
    );

    typedef struct packed {
        logic [c_gw-1:0] txid;
        logic [c_pw-1:0] payload;
    } req_t;

    int   n_checks = 0;
    int   n_errors = 0;
    req_t exp_q[$];
    int   grant_log[$];

    int   m_cnt [c_n];
    int   m_rr;
    bit   m_valid;
    bit   m_err;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model, evaluated on the falling edge for the coming rising edge
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            check_eq("rst_mem_valid", {63'd0, mem_req_valid_o}, 64'd0);
            check_eq("rst_ready", {61'd0, req_ready_o}, 64'd0);
            check_eq("rst_idle", {63'd0, idle_o}, 64'd1);
            for (int i = 0; i < c_n; i++) m_cnt[i] = 0;
            m_rr = 0; m_valid = 0; m_err = 0;
            exp_q.delete();
        end else begin
            bit             can_load, found, spur, all_zero;
            int             win, idx, p;
            logic [c_n-1:0] exp_grant, exp_rv;
            req_t           e;

            check_eq("mem_valid", {63'd0, mem_req_valid_o}, {63'd0, m_valid});
            if (mem_req_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q[0];
                    check_eq("mem_txid", {60'd0, mem_req_txid_o}, {60'd0, e.txid});
                    check_eq("mem_payload", {48'd0, mem_req_payload_o}, {48'd0, e.payload});
                    if (mem_req_ready_i) void'(exp_q.pop_front());
                end
            end

            can_load = !m_valid || mem_req_ready_i;
            found = 0; win = 0; exp_grant = '0;
            for (int k = 0; k < c_n; k++) begin
                idx = (m_rr + k) % c_n;
                if (!found && req_valid_i[idx] && m_cnt[idx] < c_max) begin
                    found = 1; win = idx;
                end
            end
            if (found && can_load) exp_grant[win] = 1'b1;
            check_eq("grant", {61'd0, req_ready_o}, {61'd0, exp_grant});
            for (int i = 0; i < c_n; i++) if (req_ready_o[i]) grant_log.push_back(i);

            p = int'(mem_rtrn_txid_i[c_gw-1:c_tid]);
            exp_rv = '0; spur = 0;
            if (mem_rtrn_valid_i) begin
                if (p < c_n && m_cnt[p] > 0) exp_rv[p] = 1'b1;
                else spur = 1;
                check_eq("rtrn_txid", {62'd0, rtrn_txid_o}, {62'd0, mem_rtrn_txid_i[c_tid-1:0]});
                check_eq("rtrn_payload", {48'd0, rtrn_payload_o}, {48'd0, mem_rtrn_payload_i});
            end
            check_eq("rtrn_valid", {61'd0, rtrn_valid_o}, {61'd0, exp_rv});

            all_zero = 1;
            for (int i = 0; i < c_n; i++) if (m_cnt[i] != 0) all_zero = 0;
            check_eq("idle", {63'd0, idle_o}, {63'd0, all_zero && !m_valid});
            check_eq("err", {63'd0, err_o}, {63'd0, m_err});

            if (found && can_load) begin
                e.txid    = {2'(win), req_txid_i[win*c_tid +: c_tid]};
                e.payload = req_payload_i[win*c_pw +: c_pw];
                exp_q.push_back(e);
                m_cnt[win]++;
                m_rr    = (win + 1) % c_n;
                m_valid = 1;
            end else if (mem_req_ready_i) begin
                m_valid = 0;
            end
            if (exp_rv != '0) m_cnt[p]--;
            if (spur) m_err = 1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic set_req(input int port, input logic [c_tid-1:0] id, input logic [c_pw-1:0] pl);
        req_txid_i[port*c_tid +: c_tid]  = id;
        req_payload_i[port*c_pw +: c_pw] = pl;
    endtask

    initial begin
        int exp_order [6];
        exp_order = '{0, 1, 2, 0, 1, 2};

        rst_ni = 1'b0;
        req_valid_i = '0; sp_req_valid_i = '0;
        req_txid_i = '0; req_payload_i = '0;
        mem_req_ready_i = 1'b1;
        mem_rtrn_valid_i = 1'b0; mem_rtrn_txid_i = '0; mem_rtrn_payload_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single request and its return
        set_req(0, 2'd2, 16'h00A5);
        req_valid_i = 3'b001;
        @(negedge clk_i) check_eq("single_grant", {61'd0, req_ready_o}, 64'd1);
        tick();
        req_valid_i = '0;
        @(negedge clk_i);
        check_eq("single_mem_valid", {63'd0, mem_req_valid_o}, 64'd1);
        check_eq("single_mem_txid", {60'd0, mem_req_txid_o}, 64'h2);
        check_eq("single_mem_payload", {48'd0, mem_req_payload_o}, 64'hA5);
        tick();
        mem_rtrn_valid_i = 1'b1; mem_rtrn_txid_i = 4'b0010; mem_rtrn_payload_i = 16'h1234;
        @(negedge clk_i);
        check_eq("single_rtrn_valid", {61'd0, rtrn_valid_o}, 64'd1);
        check_eq("single_rtrn_txid", {62'd0, rtrn_txid_o}, 64'd2);
        tick();
        mem_rtrn_valid_i = 1'b0;
        @(negedge clk_i) check_eq("single_idle", {63'd0, idle_o}, 64'd1);
        tick();

        // Round-robin fairness; fixed-priority instance alongside
        do_reset();
        grant_log.delete();
        for (int i = 0; i < c_n; i++) set_req(i, 2'(i), 16'h0100 + 16'(i));
        req_valid_i = 3'b111; sp_req_valid_i = 3'b111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (c < 4) check_eq("sp_grant", {61'd0, sp_req_ready_o}, 64'd1);
            tick();
        end
        req_valid_i = '0; sp_req_valid_i = '0;
        check_eq("rr_count", grant_log.size(), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) check_eq("rr_order", grant_log[i], exp_order[i]);

        // Outstanding limit on port 0 while port 1 proceeds
        do_reset();
        set_req(0, 2'd1, 16'h0200);
        req_valid_i = 3'b001;
        tick(); tick();
        req_valid_i = 3'b011;
        set_req(1, 2'd3, 16'h0300);
        @(negedge clk_i) check_eq("limit_p1_granted", {61'd0, req_ready_o}, 64'b010);
        tick();
        req_valid_i = 3'b001;
        mem_rtrn_valid_i = 1'b1; mem_rtrn_txid_i = 4'b0001;
        @(negedge clk_i) check_eq("limit_p0_stall", {61'd0, req_ready_o}, 64'b000);
        tick();
        mem_rtrn_valid_i = 1'b0;
        @(negedge clk_i) check_eq("limit_p0_reenable", {61'd0, req_ready_o}, 64'b001);
        tick();
        req_valid_i = '0;

        // Grant and return on port 1 together, then drain port 1 to zero
        req_valid_i = 3'b010;
        mem_rtrn_valid_i = 1'b1; mem_rtrn_txid_i = 4'b0111;
        @(negedge clk_i);
        check_eq("simul_grant", {61'd0, req_ready_o}, 64'b010);
        check_eq("simul_rtrn", {61'd0, rtrn_valid_o}, 64'b010);
        tick();
        req_valid_i = '0;
        @(negedge clk_i) check_eq("simul_cnt_kept", {61'd0, rtrn_valid_o}, 64'b010);
        tick();
        @(negedge clk_i);
        check_eq("spur_cnt0_rv", {61'd0, rtrn_valid_o}, 64'b000);
        check_eq("spur_err_late", {63'd0, err_o}, 64'd0);
        tick();
        mem_rtrn_txid_i = 4'b1100;
        @(negedge clk_i);
        check_eq("spur_err_set", {63'd0, err_o}, 64'd1);
        check_eq("spur_port3_rv", {61'd0, rtrn_valid_o}, 64'b000);
        tick();
        mem_rtrn_valid_i = 1'b0;
        tick();
        @(negedge clk_i) check_eq("spur_err_sticky", {63'd0, err_o}, 64'd1);

        // Reset while a request is held under backpressure
        tick();
        mem_req_ready_i = 1'b0;
        set_req(2, 2'd1, 16'h0500);
        req_valid_i = 3'b100;
        tick();
        @(negedge clk_i) check_eq("held_valid", {63'd0, mem_req_valid_o}, 64'd1);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("async_rst_valid", {63'd0, mem_req_valid_o}, 64'd0);
        check_eq("async_rst_err", {63'd0, err_o}, 64'd0);
        check_eq("async_rst_idle", {63'd0, idle_o}, 64'd1);
        check_eq("async_rst_ready", {61'd0, req_ready_o}, 64'd0);
        req_valid_i = '0;
        tick(); tick();
        rst_ni = 1'b1;

        // Backpressure: one grant only until the adapter accepts
        grant_log.delete();
        set_req(1, 2'd2, 16'h0400);
        req_valid_i = 3'b010;
        repeat (5) tick();
        check_eq("bp_one_grant", grant_log.size(), 64'd1);
        mem_req_ready_i = 1'b1;
        @(negedge clk_i) check_eq("bp_release", {61'd0, req_ready_o}, 64'b010);
        tick();
        req_valid_i = '0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
